inst_fetch: RTL

//  Instruction-fetch stage; drives the IF_ID register that feeds the decoder.

---
 rtl/inst_fetch_pkg.sv | 14 +
 rtl/inst_fetch_if.sv | 12 +
 rtl/inst_fetch_icache.sv | 52 +++++
 rtl/inst_fetch.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package inst_fetch_pkg;
   localparam int ADDR_W        = 32;
   localparam int INST_W        = 32;
   localparam int ICACHE_IDX_W  = 7;
   localparam int ICACHE_SIZE   = 1 << ICACHE_IDX_W;
   localparam int ICACHE_TAG_W  = ADDR_W - ICACHE_IDX_W - 2;
   localparam logic [INST_W-1:0] ZERO_WORD = '0;

   typedef enum logic {
      IF_IDLE = 1'b0,   // look up pc in the cache
      IF_WAIT = 1'b1    // word request outstanding to memory
   } fetch_state_e;
endpackage

// File: rtl/inst_fetch_if.sv
// Word-request handshake between the fetch stage and the memory controller.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic              mem_req;    // level, held until mem_done
   logic [ADDR_W-1:0] mem_addr;   // stable while mem_req is high
   logic              mem_done;   // one-cycle pulse, mem_inst valid
   logic [INST_W-1:0] mem_inst;

   modport master (output mem_req, mem_addr, input  mem_done, mem_inst);
   modport slave  (input  mem_req, mem_addr, output mem_done, mem_inst);
endinterface

// File: rtl/inst_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache: async read, sync write.
module inst_fetch_icache
   import inst_fetch_pkg::*;
#(
   parameter int IDX_BITS = ICACHE_IDX_W,
   parameter int TAG_BITS = ICACHE_TAG_W,
   parameter int DATA_W   = INST_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] ridx,
   input  logic [TAG_BITS-1:0] rtag,
   output logic                hit,
   output logic [DATA_W-1:0]   rdata,
   input  logic                we,
   input  logic [IDX_BITS-1:0] widx,
   input  logic [TAG_BITS-1:0] wtag,
   input  logic [DATA_W-1:0]   wdata
);
   localparam int SIZE = 1 << IDX_BITS;

   logic [SIZE-1:0]               valid_q, valid_d;
   logic [SIZE-1:0][TAG_BITS-1:0] tag_q, tag_d;
   logic [SIZE-1:0][DATA_W-1:0]   data_q, data_d;

   assign hit   = valid_q[ridx] && (tag_q[ridx] == rtag);
   assign rdata = data_q[ridx];

   // Line fill: mark valid and store tag/data at the write index.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (we) begin
         valid_d[widx] = 1'b1;
         tag_d[widx]   = wtag;
         data_d[widx]  = wdata;
      end
   end

   // Only the valid bits need reset; stale tags/data are masked by them.
   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   // Tag/data storage.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end
endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, cache lookup, miss handling, IF_ID output registers.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH      = ADDR_W,
   parameter int ICACHE_IDX_BITS = ICACHE_IDX_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  stall_i,
   input  logic                  jump_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i,
   inst_fetch_if.master          mem,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [INST_W-1:0]     inst_o,
   output logic                  inst_valid_o
);
   localparam int TAG_BITS = ADDR_WIDTH - ICACHE_IDX_BITS - 2;

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  discard_q, discard_d;
   logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
   logic [INST_W-1:0]     inst_q, inst_d;
   logic                  inst_valid_q, inst_valid_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

   logic                  hit;
   logic [INST_W-1:0]     hit_inst;
   logic                  cache_we;

   // Fill address comes from mem_addr_q: pc may have been redirected meanwhile.
   inst_fetch_icache #(
      .IDX_BITS (ICACHE_IDX_BITS),
      .TAG_BITS (TAG_BITS),
      .DATA_W   (INST_W)
   ) u_icache (
      .clk   (clk),
      .rst   (rst),
      .ridx  (pc_q[ICACHE_IDX_BITS+1:2]),
      .rtag  (pc_q[ADDR_WIDTH-1:ICACHE_IDX_BITS+2]),
      .hit   (hit),
      .rdata (hit_inst),
      .we    (cache_we),
      .widx  (mem_addr_q[ICACHE_IDX_BITS+1:2]),
      .wtag  (mem_addr_q[ADDR_WIDTH-1:ICACHE_IDX_BITS+2]),
      .wdata (mem.mem_inst)
   );

   // Next state: jump beats stall beats normal fetch; rdy=0 freezes everything.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      discard_d    = discard_q;
      pc_out_d     = pc_out_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      cache_we     = 1'b0;
      if (rdy) begin
         unique case (state_q)
            IF_IDLE: begin
               if (jump_i) begin
                  pc_d         = jump_addr_i;
                  inst_valid_d = 1'b0;
               end else if (!stall_i) begin
                  if (hit) begin
                     pc_out_d     = pc_q;
                     inst_d       = hit_inst;
                     inst_valid_d = 1'b1;
                     pc_d         = pc_q + ADDR_WIDTH'(4);
                  end else begin
                     inst_valid_d = 1'b0;
                     mem_req_d    = 1'b1;
                     mem_addr_d   = pc_q;
                     state_d      = IF_WAIT;
                  end
               end
            end
            IF_WAIT: begin
               if (mem.mem_done) begin
                  // The line is always filled, even when the word is dropped.
                  cache_we  = 1'b1;
                  mem_req_d = 1'b0;
                  state_d   = IF_IDLE;
                  discard_d = 1'b0;
                  if (jump_i) begin
                     pc_d         = jump_addr_i;
                     inst_valid_d = 1'b0;
                  end else if (discard_q) begin
                     inst_valid_d = 1'b0;
                  end else if (!stall_i) begin
                     pc_out_d     = pc_q;
                     inst_d       = mem.mem_inst;
                     inst_valid_d = 1'b1;
                     pc_d         = pc_q + ADDR_WIDTH'(4);
                  end
               end else if (jump_i) begin
                  // Request cannot be aborted; remember to drop its word.
                  pc_d         = jump_addr_i;
                  inst_valid_d = 1'b0;
                  discard_d    = 1'b1;
               end
            end
            default: state_d = IF_IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IF_IDLE;
         pc_q         <= '0;
         discard_q    <= 1'b0;
         pc_out_q     <= '0;
         inst_q       <= ZERO_WORD;
         inst_valid_q <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         discard_q    <= discard_d;
         pc_out_q     <= pc_out_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   assign pc_o          = pc_out_q;
   assign inst_o        = inst_q;
   assign inst_valid_o  = inst_valid_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_addr  = mem_addr_q;
endmodule
